layer_sequencer: RTL and testbench

Top-level scheduler for the TinyYOLO compute unit. It walks a descriptor table of conv layers and splits each layer into output-channel groups of NUM_FILTERS. For each group it drives the compute unit's scalar configuration and issues DMA commands in order: output write, parameter stream, pixel stream. It then waits for the group to complete and handles the done, error and abort conditions.

---
 rtl/layer_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Layer sequencer for the TinyYOLO compute unit: walks the conv-layer descriptor table,
// splits each layer into output-channel groups, configures the unit and issues DMA commands.
module layer_sequencer #(
  parameter int unsigned NUM_FILTERS    = 64,
  parameter int unsigned MAX_LAYERS     = 16,
  parameter int unsigned DESC_W         = 80,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [4:0]        num_layers,
  input  logic              desc_we,
  input  logic [3:0]        desc_waddr,
  input  logic [DESC_W-1:0] desc_wdata,
  output logic [31:0]       cfg_img_width,
  output logic [31:0]       cfg_in_channels,
  output logic [31:0]       cfg_out_channels,
  output logic [31:0]       cfg_quant_M,
  output logic [31:0]       cfg_quant_n,
  output logic              cfg_is_maxpool,
  output logic              cfg_is_1x1,
  output logic [31:0]       cfg_stride,
  output logic              dma_cmd_valid,
  input  logic              dma_cmd_ready,
  output logic [1:0]        dma_cmd_kind,
  output logic [3:0]        dma_cmd_layer,
  output logic [7:0]        dma_cmd_group,
  input  logic              cu_done,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned NF_SHIFT = $clog2(NUM_FILTERS);
  localparam int unsigned WD_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [12:0]     NF_M1   = 13'(NUM_FILTERS - 1);

  typedef enum logic [3:0] {
    StIdle, StFetch, StConfig, StIssueWr, StIssueParam, StIssuePix,
    StWaitDone, StNextGroup, StNextLayer
  } state_e;

  state_e state_q, state_d;
  logic [4:0]      layer_q, layer_d, nlayers_q, nlayers_d;
  logic [12:0]     group_q, group_d, groups_q, groups_d;
  logic [76:0]     desc_q, desc_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [31:0]     img_q, img_d, inch_q, inch_d, outch_q, outch_d, qm_q, qm_d;
  logic [31:0]     qn_q, qn_d, stride_q, stride_d;
  logic            mp_q, mp_d, k1_q, k1_d;

  logic [DESC_W-1:0] desc_table [MAX_LAYERS];
  logic [DESC_W-1:0] fetch_desc;
  logic [31:0]       grp_base, remain;
  logic              unused_rsvd;

  always_ff @(posedge clk) begin
    if (desc_we) desc_table[desc_waddr] <= desc_wdata;
  end

  assign fetch_desc  = desc_table[layer_q[3:0]];
  assign unused_rsvd = ^fetch_desc[DESC_W-1:77];

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    nlayers_d  = nlayers_q;
    group_d    = group_q;
    groups_d   = groups_q;
    desc_d     = desc_q;
    wd_d       = wd_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    img_d      = img_q;
    inch_d     = inch_q;
    outch_d    = outch_q;
    qm_d       = qm_q;
    qn_d       = qn_q;
    mp_d       = mp_q;
    k1_d       = k1_q;
    stride_d   = stride_q;
    grp_base   = 32'(group_q) << NF_SHIFT;
    remain     = 32'(desc_q[35:24]) - grp_base;

    case (state_q)
      StIdle: begin
        if (start) begin
          err_d      = 1'b0;
          err_code_d = 2'd0;
          layer_d    = 5'd0;
          nlayers_d  = num_layers;
          if (num_layers == 5'd0) done_d = 1'b1;
          else                    state_d = StFetch;
        end
      end
      StFetch: begin
        desc_d   = fetch_desc[76:0];
        groups_d = ({1'b0, fetch_desc[35:24]} + NF_M1) >> NF_SHIFT;
        group_d  = 13'd0;
        if (fetch_desc[35:24] == 12'd0 || fetch_desc[23:12] == 12'd0) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = StNextLayer;
        end else begin
          state_d = StConfig;
        end
      end
      StConfig: begin
        img_d    = 32'(desc_q[11:0]);
        inch_d   = 32'(desc_q[23:12]);
        outch_d  = (remain > NUM_FILTERS) ? NUM_FILTERS : remain;
        qm_d     = desc_q[67:36];
        qn_d     = 32'(desc_q[72:68]);
        mp_d     = desc_q[73];
        k1_d     = desc_q[74];
        stride_d = 32'(desc_q[76:75]);
        state_d  = StIssueWr;
      end
      // valid rises one cycle after entering each issue state and drops after acceptance
      StIssueWr, StIssueParam, StIssuePix: begin
        if (valid_q && dma_cmd_ready) begin
          wd_d = '0;
          case (state_q)
            StIssueWr:    state_d = StIssueParam;
            StIssueParam: state_d = StIssuePix;
            default:      state_d = StWaitDone;
          endcase
        end else begin
          valid_d = 1'b1;
        end
      end
      StWaitDone: begin
        if (cu_done) begin
          state_d = StNextGroup;
        end else if (wd_q == WD_LAST) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StNextGroup: begin
        if (group_q == groups_q - 13'd1) begin
          state_d = StNextLayer;
        end else begin
          group_d = group_q + 13'd1;
          state_d = StConfig;
        end
      end
      StNextLayer: begin
        if (layer_q == nlayers_q - 5'd1) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          layer_d = layer_q + 5'd1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a handshake in the same cycle.
    if (abort && state_q != StIdle) begin
      state_d    = StIdle;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b1;
      err_code_d = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      layer_q    <= '0;
      nlayers_q  <= '0;
      group_q    <= '0;
      groups_q   <= '0;
      desc_q     <= '0;
      wd_q       <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      img_q      <= '0;
      inch_q     <= '0;
      outch_q    <= '0;
      qm_q       <= '0;
      qn_q       <= '0;
      mp_q       <= 1'b0;
      k1_q       <= 1'b0;
      stride_q   <= '0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      nlayers_q  <= nlayers_d;
      group_q    <= group_d;
      groups_q   <= groups_d;
      desc_q     <= desc_d;
      wd_q       <= wd_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      img_q      <= img_d;
      inch_q     <= inch_d;
      outch_q    <= outch_d;
      qm_q       <= qm_d;
      qn_q       <= qn_d;
      mp_q       <= mp_d;
      k1_q       <= k1_d;
      stride_q   <= stride_d;
    end
  end

  always_comb begin
    case (state_q)
      StIssueParam: dma_cmd_kind = 2'd1;
      StIssuePix:   dma_cmd_kind = 2'd2;
      default:      dma_cmd_kind = 2'd0;
    endcase
  end

  assign dma_cmd_valid    = valid_q;
  assign dma_cmd_layer    = layer_q[3:0];
  assign dma_cmd_group    = group_q[7:0];
  assign busy             = (state_q != StIdle);
  assign done             = done_q;
  assign err              = err_q;
  assign err_code         = err_code_q;
  assign cfg_img_width    = img_q;
  assign cfg_in_channels  = inch_q;
  assign cfg_out_channels = outch_q;
  assign cfg_quant_M      = qm_q;
  assign cfg_quant_n      = qn_q;
  assign cfg_is_maxpool   = mp_q;
  assign cfg_is_1x1       = k1_q;
  assign cfg_stride       = stride_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: expected DMA commands are queued at launch and
// compared at each handshake; a small compute-unit model answers PIX commands with cu_done.
module tb_layer_sequencer;
  localparam int unsigned TIMEOUT = 128;

  logic        clk = 1'b0;
  logic        rst, start, abort, desc_we, dma_cmd_ready, cu_done;
  logic [4:0]  num_layers;
  logic [3:0]  desc_waddr;
  logic [79:0] desc_wdata;
  logic [31:0] cfg_img_width, cfg_in_channels, cfg_out_channels, cfg_quant_M;
  logic [31:0] cfg_quant_n, cfg_stride;
  logic        cfg_is_maxpool, cfg_is_1x1, dma_cmd_valid, busy, done, err;
  logic [1:0]  dma_cmd_kind, err_code;
  logic [3:0]  dma_cmd_layer;
  logic [7:0]  dma_cmd_group;

  always #5 clk = ~clk;

  layer_sequencer #(
    .NUM_FILTERS(64), .MAX_LAYERS(16), .DESC_W(80), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_layers(num_layers),
    .desc_we(desc_we), .desc_waddr(desc_waddr), .desc_wdata(desc_wdata),
    .cfg_img_width(cfg_img_width), .cfg_in_channels(cfg_in_channels),
    .cfg_out_channels(cfg_out_channels), .cfg_quant_M(cfg_quant_M),
    .cfg_quant_n(cfg_quant_n), .cfg_is_maxpool(cfg_is_maxpool), .cfg_is_1x1(cfg_is_1x1),
    .cfg_stride(cfg_stride), .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
    .dma_cmd_kind(dma_cmd_kind), .dma_cmd_layer(dma_cmd_layer),
    .dma_cmd_group(dma_cmd_group), .cu_done(cu_done), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  layer;
    logic [7:0]  grp;
    logic [31:0] cout;
  } cmd_t;

  cmd_t sb[$];
  int   n_checks = 0, n_pass = 0, hs_count = 0, done_count = 0;
  int   cu_cnt = 0, cu_delay = 0;
  logic stall_pend = 1'b0, done_prev = 1'b0;
  logic [1:0] h_kind;
  logic [3:0] h_layer;
  logic [7:0] h_grp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // One clock: sample and score at negedge, return 1 time unit after the next posedge.
  task automatic tick();
    cmd_t e;
    @(negedge clk);
    if (stall_pend) begin
      check("hold_valid", dma_cmd_valid, 1);
      check("hold_kind", dma_cmd_kind, h_kind);
      check("hold_layer", dma_cmd_layer, h_layer);
      check("hold_group", dma_cmd_group, h_grp);
    end
    stall_pend = dma_cmd_valid && !dma_cmd_ready && !abort && !rst;
    h_kind = dma_cmd_kind;
    h_layer = dma_cmd_layer;
    h_grp = dma_cmd_group;
    if (done) begin
      done_count++;
      check("done_single_cycle", done_prev, 0);
    end
    done_prev = done;
    cu_done = 1'b0;
    if (cu_cnt > 0) begin
      cu_cnt--;
      if (cu_cnt == 0) cu_done = 1'b1;
    end
    if (dma_cmd_valid && dma_cmd_ready && !abort && !rst) begin
      hs_count++;
      check("sb_expected_cmd", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("cmd_kind", dma_cmd_kind, e.kind);
        check("cmd_layer", dma_cmd_layer, e.layer);
        check("cmd_group", dma_cmd_group, e.grp);
        check("cmd_cfg_out", cfg_out_channels, e.cout);
      end
      if (dma_cmd_kind == 2'd2 && cu_delay > 0) cu_cnt = cu_delay;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_desc(input int idx, input int img, input int inch, input int outch,
                            input int qm, input int qn, input bit mp, input bit k1,
                            input int stride);
    desc_we = 1'b1;
    desc_waddr = 4'(idx);
    desc_wdata = {3'b000, 2'(stride), k1, mp, 5'(qn), 32'(qm), 12'(outch), 12'(inch),
                  12'(img)};
    tick();
    desc_we = 1'b0;
  endtask

  task automatic push_layer(input int layer, input int outch);
    int ng, rem;
    cmd_t e;
    ng = (outch + 63) / 64;
    for (int g = 0; g < ng; g++) begin
      rem = outch - 64 * g;
      for (int k = 0; k < 3; k++) begin
        e.kind = 2'(k);
        e.layer = 4'(layer);
        e.grp = 8'(g);
        e.cout = (rem > 64) ? 32'd64 : 32'(rem);
        sb.push_back(e);
      end
    end
  endtask

  task automatic launch(input int nl);
    num_layers = 5'(nl);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check("idle_in_budget", busy, 0);
    tick();
  endtask

  task automatic wait_cmd(input logic [1:0] kind);
    for (int i = 0; i < 50 && !(dma_cmd_valid && dma_cmd_kind == kind); i++) tick();
    check("cmd_offered", dma_cmd_valid && dma_cmd_kind == kind, 1);
  endtask

  int hs0, dn0;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; desc_we = 1'b0; dma_cmd_ready = 1'b0;
    cu_done = 1'b0; num_layers = 5'd0; desc_waddr = 4'd0; desc_wdata = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", dma_cmd_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_cfg_out", cfg_out_channels, 0);
    check("rst_cfg_img", cfg_img_width, 0);
    rst = 1'b0;
    tick();

    // Single layer, 64 output channels
    write_desc(0, 416, 3, 64, 32'h1234_5678, 5, 1'b1, 1'b0, 2);
    push_layer(0, 64);
    dma_cmd_ready = 1'b1; cu_delay = 100; hs0 = hs_count; dn0 = done_count;
    launch(1);
    check("busy_after_start", busy, 1);
    tick(); tick();
    check("lat_not_early", dma_cmd_valid, 0);
    tick();
    check("lat_first_valid", dma_cmd_valid, 1);
    check("lat_first_kind", dma_cmd_kind, 0);
    wait_idle(400);
    check("t1_handshakes", hs_count - hs0, 3);
    check("t1_done", done_count - dn0, 1);
    check("t1_err", err, 0);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_img", cfg_img_width, 416);
    check("t1_inch", cfg_in_channels, 3);
    check("t1_cout", cfg_out_channels, 64);
    check("t1_qm", cfg_quant_M, 32'h1234_5678);
    check("t1_qn", cfg_quant_n, 5);
    check("t1_maxpool", cfg_is_maxpool, 1);
    check("t1_1x1", cfg_is_1x1, 0);
    check("t1_stride", cfg_stride, 2);

    // 160 output channels -> groups of 64, 64, 32
    write_desc(0, 52, 16, 160, 7, 3, 1'b0, 1'b1, 1);
    push_layer(0, 160);
    cu_delay = 10; hs0 = hs_count; dn0 = done_count;
    launch(1);
    wait_idle(400);
    check("t2_handshakes", hs_count - hs0, 9);
    check("t2_done", done_count - dn0, 1);
    check("t2_sb_empty", sb.size(), 0);
    check("t2_last_cout", cfg_out_channels, 32);

    // Ready held low for 7 cycles in the parameter command
    write_desc(0, 26, 8, 64, 1, 1, 1'b0, 1'b0, 1);
    push_layer(0, 64);
    dma_cmd_ready = 1'b0; cu_delay = 10; hs0 = hs_count; dn0 = done_count;
    launch(1);
    wait_cmd(2'd0);
    dma_cmd_ready = 1'b1; tick(); dma_cmd_ready = 1'b0;
    wait_cmd(2'd1);
    repeat (7) tick();
    check("t3_no_hs_during_stall", hs_count - hs0, 1);
    check("t3_valid_held", dma_cmd_valid, 1);
    check("t3_kind_held", dma_cmd_kind, 1);
    dma_cmd_ready = 1'b1;
    wait_idle(200);
    check("t3_handshakes", hs_count - hs0, 3);
    check("t3_done", done_count - dn0, 1);
    check("t3_sb_empty", sb.size(), 0);

    // Three layers with a zero-channel middle layer
    write_desc(0, 13, 4, 32, 1, 1, 1'b0, 1'b0, 1);
    write_desc(1, 13, 4, 0, 1, 1, 1'b0, 1'b0, 1);
    write_desc(2, 13, 4, 64, 1, 1, 1'b0, 1'b0, 1);
    push_layer(0, 32);
    push_layer(2, 64);
    cu_delay = 5; hs0 = hs_count; dn0 = done_count;
    launch(3);
    wait_idle(400);
    check("t4_handshakes", hs_count - hs0, 6);
    check("t4_done", done_count - dn0, 1);
    check("t4_err", err, 1);
    check("t4_err_code", err_code, 2);
    check("t4_sb_empty", sb.size(), 0);

    // Watchdog: cu_done never arrives
    write_desc(0, 13, 4, 64, 1, 1, 1'b0, 1'b0, 1);
    push_layer(0, 64);
    cu_delay = 0; hs0 = hs_count; dn0 = done_count;
    launch(1);
    for (int i = 0; i < 50 && hs_count < hs0 + 3; i++) tick();
    check("t5_reach_wait", hs_count - hs0, 3);
    repeat (TIMEOUT - 1) tick();
    check("t5_busy_before_timeout", busy, 1);
    check("t5_err_before_timeout", err, 0);
    tick();
    check("t5_busy_after_timeout", busy, 0);
    check("t5_err", err, 1);
    check("t5_err_code", err_code, 1);
    tick();
    check("t5_no_done", done_count - dn0, 0);
    push_layer(0, 64);
    cu_delay = 5; dn0 = done_count;
    launch(1);
    check("t5_err_cleared", err, 0);
    check("t5_code_cleared", err_code, 0);
    wait_idle(200);
    check("t5_rerun_done", done_count - dn0, 1);

    // Abort concurrent with the pixel-command handshake
    push_layer(0, 64);
    void'(sb.pop_back());
    dma_cmd_ready = 1'b0; cu_delay = 0; hs0 = hs_count;
    launch(1);
    wait_cmd(2'd0);
    dma_cmd_ready = 1'b1; tick(); dma_cmd_ready = 1'b0;
    wait_cmd(2'd1);
    dma_cmd_ready = 1'b1; tick(); dma_cmd_ready = 1'b0;
    wait_cmd(2'd2);
    dma_cmd_ready = 1'b1; abort = 1'b1;
    tick();
    dma_cmd_ready = 1'b0; abort = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_valid", dma_cmd_valid, 0);
    check("t6_err", err, 1);
    check("t6_err_code", err_code, 3);
    check("t6_handshakes", hs_count - hs0, 2);
    check("t6_sb_empty", sb.size(), 0);
    cu_cnt = 1;
    tick(); tick();
    check("t6_cu_done_ignored", busy, 0);
    check("t6_code_kept", err_code, 3);
    dn0 = done_count;
    launch(0);
    check("t6_zero_layers_done", done, 1);
    check("t6_zero_layers_idle", busy, 0);
    check("t6_zero_layers_err", err, 0);
    tick();
    check("t6_done_dropped", done, 0);
    check("t6_done_count", done_count - dn0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
